riscv_timer_master: RTL and testbench
=====================================

Name: riscv_timer_master

Overview:
- Core-side initiator for the machine timer register interface.
- Accepts load/store requests from the LSU in the CLINT address window and decodes address and size.
- Drives the timer's write-enable, read-enable, register-select and write-data strobes, and samples its read data.
- Returns extended load data or an error, and registers the timer interrupt as MTIP for the CSR/trap unit.

Parameters:
- MTIMECMP_OFF, 16'h4000, byte offset of 64-bit mtimecmp in CLINT window
- MTIME_OFF, 16'hBFF8, byte offset of 64-bit mtime in CLINT window

Ports:
- i_riscv_timer_clk  in  1  clock
- i_riscv_timer_rst  in  1  reset, asynchronous, active-high
- i_riscv_tmaster_req_valid  in  1  request valid
- o_riscv_tmaster_req_ready  out  1  request accepted when valid&ready
- i_riscv_tmaster_req_we  in  1  1=store, 0=load
- i_riscv_tmaster_req_addr  in  16  byte offset in CLINT window
- i_riscv_tmaster_req_size  in  2  0=B, 1=H, 2=W, 3=D
- i_riscv_tmaster_req_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- i_riscv_tmaster_req_wdata  in  64  store data, right-aligned
- o_riscv_tmaster_resp_valid  out  1  one-cycle response pulse
- o_riscv_tmaster_resp_rdata  out  64  load result; 0 for stores/errors
- o_riscv_tmaster_resp_err  out  1  access fault, qualified by resp_valid
- o_riscv_timer_wren  out  1  timer write strobe
- o_riscv_timer_rden  out  1  timer read strobe
- o_riscv_timer_regsel  out  2  01=mtime, 10=mtimecmp, 00 when idle
- o_riscv_timer_wdata  out  64  timer write data
- i_riscv_timer_rdata  in  64  timer read data, combinational, same cycle as rden
- i_riscv_timer_irq  in  1  timer interrupt level
- o_riscv_tmaster_mtip  out  1  registered i_riscv_timer_irq

Behaviour:
- Reset: all outputs 0 except req_ready=1. FSM=IDLE, request buffers cleared. Reset mid-operation aborts at once; no partial write is issued.
- FSM states: IDLE, RD, WR, RESP. All timer-side outputs are decoded from state and latched request registers only (Moore).
- IDLE: req_ready=1. On valid, latch we/addr/size/unsigned/wdata, then decode:
  - Register select: addr[15:3]==MTIME_OFF[15:3] selects mtime (01); ==MTIMECMP_OFF[15:3] selects mtimecmp (10); otherwise error.
  - Misaligned (addr[2:0] not a multiple of 2^size bytes) is an error.
  - Error -> RESP with err=1.
  - Load -> RD.
  - Store with size=3 -> WR.
  - Store with size<3 -> RD (read-modify-write).
- RD: rden=1 with regsel; capture i_riscv_timer_rdata into data buffer.
  - RMW store: merged = (buf & ~mask) | ((wdata << 8*off) & mask), where mask = ((1<<(8<<size))-1) << 8*off and off=addr[2:0]; next WR.
  - Load: next RESP.
- WR: wren=1, regsel, wdata = merged (full wdata for size=3). Next RESP.
- RESP: resp_valid=1 for exactly one cycle, no backpressure; next IDLE. req_ready=0 in RD/WR/RESP.
- Load result = (buf >> 8*off) truncated to 8<<size bits, then sign-extended (unsigned=0) or zero-extended. No extension for size=3.
- Latency from accept cycle 0:
  - error: resp at cycle 1
  - load: rden cycle 1, resp cycle 2
  - 64-bit store: wren cycle 1, resp cycle 2
  - sub-word store: rden 1, wren 2, resp 3
- MTIME RMW: unmodified bytes take the value sampled in RD. The one-tick increment between RD and WR is lost by design and not compensated.
- wren and rden are never high together. Timer strobes are only asserted for valid, aligned, mapped requests.
- o_riscv_tmaster_mtip <= i_riscv_timer_irq every cycle, independent of FSM state; 1-cycle delay.

Test Plan:
- Reset, then SD 0x100 @0x4000 -> cycle1 wren=1 regsel=10 wdata=0x100; cycle2 resp_valid=1 err=0 rdata=0. Once mtime>=0x100, mtip rises 1 cycle after irq.
- Loads after SD 0x8000_0001_8000_0002 @0x4000:
  - LW @0x4000 -> rdata 0xFFFF_FFFF_8000_0002
  - LWU @0x4004 -> 0x0000_0000_8000_0001
  - LB @0x4007 -> 0xFFFF_FFFF_FFFF_FF80
  - LD @0x4000 -> 0x8000_0001_8000_0002
- With mtimecmp=0x1111_2222_3333_4444, SH 0xABCD @0x4002 -> rden cycle1, wren cycle2 wdata 0x1111_2222_ABCD_4444, resp cycle3. Subsequent LD returns that value.
- LW @0x4002 (misaligned) and LD @0x0000 (unmapped) -> resp_err=1 at cycle1. rden/wren stay 0 throughout; mtimecmp unchanged.
- Assert reset while in WR -> wren drops in the same cycle, mtimecmp holds its old value, resp_valid=0. req_ready=1 after release.
- req_valid held high with two queued requests -> second accepted only in the cycle after RESP (req_ready=1). No strobe overlap between the two requests.

Source files
------------

// File: rtl/riscv_timer_master.sv
// Core-side initiator for the CLINT machine-timer registers: decodes LSU requests,
// drives timer strobes (with read-modify-write for sub-word stores) and registers MTIP.
module riscv_timer_master #(
   parameter logic [15:0] MTIMECMP_OFF = 16'h4000,
   parameter logic [15:0] MTIME_OFF    = 16'hBFF8
) (
   input  logic        i_riscv_timer_clk,
   input  logic        i_riscv_timer_rst,
   input  logic        i_riscv_tmaster_req_valid,
   output logic        o_riscv_tmaster_req_ready,
   input  logic        i_riscv_tmaster_req_we,
   input  logic [15:0] i_riscv_tmaster_req_addr,
   input  logic [1:0]  i_riscv_tmaster_req_size,
   input  logic        i_riscv_tmaster_req_unsigned,
   input  logic [63:0] i_riscv_tmaster_req_wdata,
   output logic        o_riscv_tmaster_resp_valid,
   output logic [63:0] o_riscv_tmaster_resp_rdata,
   output logic        o_riscv_tmaster_resp_err,
   output logic        o_riscv_timer_wren,
   output logic        o_riscv_timer_rden,
   output logic [1:0]  o_riscv_timer_regsel,
   output logic [63:0] o_riscv_timer_wdata,
   input  logic [63:0] i_riscv_timer_rdata,
   input  logic        i_riscv_timer_irq,
   output logic        o_riscv_tmaster_mtip
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state;
   logic        we_q;
   logic [2:0]  off_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [63:0] wdata_q;

   logic [1:0]  req_sel;
   logic        req_err;
   logic [2:0]  align_mask;
   logic [5:0]  bit_off;
   logic [63:0] shifted;
   logic [63:0] lane_mask;
   logic [63:0] merged;
   logic [63:0] load_res;

   // Request decode, evaluated on the raw inputs during the accept cycle
   always_comb begin
      req_sel = 2'b00;
      if (i_riscv_tmaster_req_addr[15:3] == MTIME_OFF[15:3])
         req_sel = 2'b01;
      else if (i_riscv_tmaster_req_addr[15:3] == MTIMECMP_OFF[15:3])
         req_sel = 2'b10;
      case (i_riscv_tmaster_req_size)
         2'd0:    align_mask = 3'b000;
         2'd1:    align_mask = 3'b001;
         2'd2:    align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
      req_err = (req_sel == 2'b00) || ((i_riscv_tmaster_req_addr[2:0] & align_mask) != 3'b000);
   end

   // Byte-lane merge and load extraction on the value read back in RD
   always_comb begin
      bit_off = {off_q, 3'b000};
      shifted = i_riscv_timer_rdata >> bit_off;
      case (size_q)
         2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
         2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
         2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
         default: lane_mask = '1;
      endcase
      lane_mask = lane_mask << bit_off;
      merged    = (i_riscv_timer_rdata & ~lane_mask) | ((wdata_q << bit_off) & lane_mask);
      case (size_q)
         2'd0:    load_res = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
         2'd1:    load_res = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
         2'd2:    load_res = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
         default: load_res = shifted;
      endcase
   end

   always_ff @(posedge i_riscv_timer_clk or posedge i_riscv_timer_rst) begin
      if (i_riscv_timer_rst) begin
         state                      <= IDLE;
         we_q                       <= 1'b0;
         off_q                      <= '0;
         size_q                     <= '0;
         uns_q                      <= 1'b0;
         wdata_q                    <= '0;
         o_riscv_tmaster_req_ready  <= 1'b1;
         o_riscv_tmaster_resp_valid <= 1'b0;
         o_riscv_tmaster_resp_rdata <= '0;
         o_riscv_tmaster_resp_err   <= 1'b0;
         o_riscv_timer_wren         <= 1'b0;
         o_riscv_timer_rden         <= 1'b0;
         o_riscv_timer_regsel       <= '0;
         o_riscv_timer_wdata        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_riscv_tmaster_req_valid) begin
                  we_q                      <= i_riscv_tmaster_req_we;
                  off_q                     <= i_riscv_tmaster_req_addr[2:0];
                  size_q                    <= i_riscv_tmaster_req_size;
                  uns_q                     <= i_riscv_tmaster_req_unsigned;
                  wdata_q                   <= i_riscv_tmaster_req_wdata;
                  o_riscv_tmaster_req_ready <= 1'b0;
                  if (req_err) begin
                     state                      <= RESP;
                     o_riscv_tmaster_resp_valid <= 1'b1;
                     o_riscv_tmaster_resp_err   <= 1'b1;
                     o_riscv_tmaster_resp_rdata <= '0;
                  end else if (i_riscv_tmaster_req_we && i_riscv_tmaster_req_size == 2'd3) begin
                     state                <= WR;
                     o_riscv_timer_wren   <= 1'b1;
                     o_riscv_timer_regsel <= req_sel;
                     o_riscv_timer_wdata  <= i_riscv_tmaster_req_wdata;
                  end else begin
                     state                <= RD;
                     o_riscv_timer_rden   <= 1'b1;
                     o_riscv_timer_regsel <= req_sel;
                  end
               end
            end
            RD: begin
               o_riscv_timer_rden <= 1'b0;
               if (we_q) begin
                  state               <= WR;
                  o_riscv_timer_wren  <= 1'b1;
                  o_riscv_timer_wdata <= merged;
               end else begin
                  state                      <= RESP;
                  o_riscv_timer_regsel       <= '0;
                  o_riscv_tmaster_resp_valid <= 1'b1;
                  o_riscv_tmaster_resp_err   <= 1'b0;
                  o_riscv_tmaster_resp_rdata <= load_res;
               end
            end
            WR: begin
               state                      <= RESP;
               o_riscv_timer_wren         <= 1'b0;
               o_riscv_timer_regsel       <= '0;
               o_riscv_timer_wdata        <= '0;
               o_riscv_tmaster_resp_valid <= 1'b1;
               o_riscv_tmaster_resp_err   <= 1'b0;
               o_riscv_tmaster_resp_rdata <= '0;
            end
            default: begin
               state                      <= IDLE;
               o_riscv_tmaster_resp_valid <= 1'b0;
               o_riscv_tmaster_resp_err   <= 1'b0;
               o_riscv_tmaster_resp_rdata <= '0;
               o_riscv_tmaster_req_ready  <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge i_riscv_timer_clk or posedge i_riscv_timer_rst) begin
      if (i_riscv_timer_rst)
         o_riscv_tmaster_mtip <= 1'b0;
      else
         o_riscv_tmaster_mtip <= i_riscv_timer_irq;
   end

endmodule

// File: tb/tb_riscv_timer_master.sv
// Bench for riscv_timer_master: behavioural CLINT timer plus a byte-level reference
// model of both registers; directed scenarios followed by randomized requests.
module tb_riscv_timer_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        timer_wren;
   logic        timer_rden;
   logic [1:0]  timer_regsel;
   logic [63:0] timer_wdata;
   logic [63:0] timer_rdata;
   logic        timer_irq;
   logic        mtip;

   int total = 0;
   int bad   = 0;

   riscv_timer_master #(.MTIMECMP_OFF(16'h4000), .MTIME_OFF(16'hBFF8)) dut (
      .i_riscv_timer_clk           (clk),
      .i_riscv_timer_rst           (rst),
      .i_riscv_tmaster_req_valid   (req_valid),
      .o_riscv_tmaster_req_ready   (req_ready),
      .i_riscv_tmaster_req_we      (req_we),
      .i_riscv_tmaster_req_addr    (req_addr),
      .i_riscv_tmaster_req_size    (req_size),
      .i_riscv_tmaster_req_unsigned(req_unsigned),
      .i_riscv_tmaster_req_wdata   (req_wdata),
      .o_riscv_tmaster_resp_valid  (resp_valid),
      .o_riscv_tmaster_resp_rdata  (resp_rdata),
      .o_riscv_tmaster_resp_err    (resp_err),
      .o_riscv_timer_wren          (timer_wren),
      .o_riscv_timer_rden          (timer_rden),
      .o_riscv_timer_regsel        (timer_regsel),
      .o_riscv_timer_wdata         (timer_wdata),
      .i_riscv_timer_rdata         (timer_rdata),
      .i_riscv_timer_irq           (timer_irq),
      .o_riscv_tmaster_mtip        (mtip)
   );

   always #5 clk = ~clk;

   // Behavioural timer peripheral; tick_en freezes mtime so reads are predictable
   logic [63:0] t_mtime    = '0;
   logic [63:0] t_mtimecmp = '1;
   bit          tick_en    = 1'b1;

   always @(posedge clk) begin
      if (timer_wren) begin
         if (timer_regsel == 2'b01)      t_mtime    <= timer_wdata;
         else if (timer_regsel == 2'b10) t_mtimecmp <= timer_wdata;
      end else if (tick_en) begin
         t_mtime <= t_mtime + 64'd1;
      end
   end

   assign timer_rdata = !timer_rden ? '0 :
                        (timer_regsel == 2'b01) ? t_mtime :
                        (timer_regsel == 2'b10) ? t_mtimecmp : '0;
   assign timer_irq   = (t_mtime >= t_mtimecmp);

   // Reference register contents: index 0 = mtime, 1 = mtimecmp
   logic [63:0] ref_regs [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_load(input int idx, input int off, input int size, input bit uns);
      logic [63:0] v;
      int n;
      v = '0;
      n = 1 << size;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_regs[idx][8*(off+i) +: 8];
      if (!uns && n < 8 && v[8*n-1])
         for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic ref_store(input int idx, input int off, input int size, input logic [63:0] wd);
      for (int i = 0; i < (1 << size); i++) ref_regs[idx][8*(off+i) +: 8] = wd[8*i +: 8];
   endtask

   // One request from accept to response, with every timing and data check against the model
   task automatic do_req(input logic we, input logic [15:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wd, output logic [63:0] rd);
      int idx, off, e_rc, e_wc, e_vc;
      int rc, rn, wc, wn, vc, vn, ovl;
      bit err;
      logic [1:0]  e_sel, sel_r, sel_w;
      logic [63:0] e_rd, e_wd, wd_seen;
      logic        er;
      off = int'(addr[2:0]);
      idx = -1;
      if ((addr & 16'hFFF8) == 16'hBFF8) idx = 0;
      if ((addr & 16'hFFF8) == 16'h4000) idx = 1;
      err   = (idx < 0) || (off % (1 << size) != 0);
      e_sel = (idx == 0) ? 2'b01 : 2'b10;
      e_rd  = '0;
      e_wd  = '0;
      if (err) begin
         e_rc = 0; e_wc = 0; e_vc = 1;
      end else if (!we) begin
         e_rc = 1; e_wc = 0; e_vc = 2;
         e_rd = ref_load(idx, off, int'(size), uns);
      end else begin
         e_rc = (size == 2'd3) ? 0 : 1;
         e_wc = (size == 2'd3) ? 1 : 2;
         e_vc = e_wc + 1;
         ref_store(idx, off, int'(size), wd);
         e_wd = ref_regs[idx];
      end

      @(negedge clk);
      check("ready_before_req", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      rc = 0; rn = 0; wc = 0; wn = 0; vc = 0; vn = 0; ovl = 0;
      sel_r = '0; sel_w = '0; wd_seen = '0; rd = '0; er = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         if (timer_rden) begin rn++; if (rc == 0) rc = c; sel_r = timer_regsel; end
         if (timer_wren) begin wn++; if (wc == 0) wc = c; sel_w = timer_regsel; wd_seen = timer_wdata; end
         if (resp_valid) begin vn++; if (vc == 0) vc = c; rd = resp_rdata; er = resp_err; end
         if (timer_rden && timer_wren) ovl++;
         if (c < 5) @(negedge clk);
      end
      check("rden_cycle",  64'(rc), 64'(e_rc));
      check("rden_count",  64'(rn), (e_rc != 0) ? 64'd1 : 64'd0);
      check("wren_cycle",  64'(wc), 64'(e_wc));
      check("wren_count",  64'(wn), (e_wc != 0) ? 64'd1 : 64'd0);
      check("resp_cycle",  64'(vc), 64'(e_vc));
      check("resp_count",  64'(vn), 64'd1);
      check("resp_err",    {63'd0, er}, {63'd0, err});
      check("resp_rdata",  rd, e_rd);
      check("strobe_overlap", 64'(ovl), 64'd0);
      if (e_rc != 0) check("rd_regsel", {62'd0, sel_r}, {62'd0, e_sel});
      if (e_wc != 0) begin
         check("wr_regsel", {62'd0, sel_w}, {62'd0, e_sel});
         check("wr_wdata",  wd_seen, e_wd);
      end
   endtask

   logic [63:0] rd, rd_a, wd_b, exp_a;
   int acc_a, acc_b, resp_a, ovl, phase, waited;
   logic [15:0] raddr;
   logic [1:0]  rsize;
   int roff;

   initial begin
      ref_regs[0] = '0;
      ref_regs[1] = '1;
      repeat (2) @(negedge clk);
      check("rst_ready",      {63'd0, req_ready},   64'd1);
      check("rst_resp_valid", {63'd0, resp_valid},  64'd0);
      check("rst_resp_rdata", resp_rdata,           64'd0);
      check("rst_wren",       {63'd0, timer_wren},  64'd0);
      check("rst_rden",       {63'd0, timer_rden},  64'd0);
      check("rst_regsel",     {62'd0, timer_regsel}, 64'd0);
      check("rst_wdata",      timer_wdata,          64'd0);
      check("rst_mtip",       {63'd0, mtip},        64'd0);
      rst = 1'b0;

      // mtimecmp = 0x100 while mtime runs; MTIP follows irq by one cycle
      do_req(1'b1, 16'h4000, 2'd3, 1'b0, 64'h100, rd);
      waited = 0;
      while (!timer_irq && waited < 1000) begin @(negedge clk); waited++; end
      check("irq_timeout", {63'd0, timer_irq}, 64'd1);
      check("mtip_before", {63'd0, mtip}, 64'd0);
      @(negedge clk);
      check("mtip_after", {63'd0, mtip}, 64'd1);

      tick_en = 1'b0;
      do_req(1'b1, 16'hBFF8, 2'd3, 1'b0, 64'd0, rd);

      do_req(1'b1, 16'h4000, 2'd3, 1'b0, 64'h8000_0001_8000_0002, rd);
      do_req(1'b0, 16'h4000, 2'd2, 1'b0, '0, rd); check("lw",  rd, 64'hFFFF_FFFF_8000_0002);
      do_req(1'b0, 16'h4004, 2'd2, 1'b1, '0, rd); check("lwu", rd, 64'h0000_0000_8000_0001);
      do_req(1'b0, 16'h4007, 2'd0, 1'b0, '0, rd); check("lb",  rd, 64'hFFFF_FFFF_FFFF_FF80);
      do_req(1'b0, 16'h4000, 2'd3, 1'b0, '0, rd); check("ld",  rd, 64'h8000_0001_8000_0002);

      do_req(1'b1, 16'h4000, 2'd3, 1'b0, 64'h1111_2222_3333_4444, rd);
      do_req(1'b1, 16'h4002, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_ABCD, rd);
      do_req(1'b0, 16'h4000, 2'd3, 1'b0, '0, rd); check("sh_readback", rd, 64'h1111_2222_ABCD_4444);

      do_req(1'b0, 16'h4002, 2'd2, 1'b0, '0, rd);
      do_req(1'b0, 16'h0000, 2'd3, 1'b0, '0, rd);
      do_req(1'b1, 16'h4001, 2'd3, 1'b0, 64'hDEAD, rd);
      do_req(1'b0, 16'h4000, 2'd3, 1'b0, '0, rd); check("err_no_write", rd, 64'h1111_2222_ABCD_4444);

      // Reset during WR: strobe drops immediately, mtimecmp keeps its old value
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h4000; req_size = 2'd3; req_wdata = 64'h5555;
      @(negedge clk);
      req_valid = 1'b0;
      check("wr_before_rst", {63'd0, timer_wren}, 64'd1);
      #2 rst = 1'b1;
      #1;
      check("wren_in_rst",   {63'd0, timer_wren},   64'd0);
      check("regsel_in_rst", {62'd0, timer_regsel}, 64'd0);
      check("resp_in_rst",   {63'd0, resp_valid},   64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mtimecmp_held", t_mtimecmp, ref_regs[1]);
      check("ready_after_rst", {63'd0, req_ready}, 64'd1);
      check("resp_after_rst",  {63'd0, resp_valid}, 64'd0);

      // Back-to-back: valid held high, second request waits for the cycle after RESP
      exp_a = ref_load(1, 0, 3, 1'b0);
      wd_b  = {$urandom, $urandom};
      acc_a = -1; acc_b = -1; resp_a = -1; ovl = 0; phase = 0; rd_a = '0;
      for (int c = 0; c < 12; c++) begin
         if (timer_rden && timer_wren) ovl++;
         if (resp_valid && resp_a < 0) begin resp_a = c; rd_a = resp_rdata; end
         if (phase == 0) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4000; req_size = 2'd3; req_unsigned = 1'b0;
            if (req_ready) begin acc_a = c; phase = 1; end
         end else if (phase == 1) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h4004; req_size = 2'd2; req_wdata = wd_b;
            if (req_ready) begin acc_b = c; phase = 2; end
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      ref_store(1, 4, 2, wd_b);
      check("q_acc_a",  64'(acc_a),  64'd0);
      check("q_resp_a", 64'(resp_a), 64'd2);
      check("q_acc_b",  64'(acc_b),  64'(resp_a + 1));
      check("q_rdata_a", rd_a, exp_a);
      check("q_overlap", 64'(ovl), 64'd0);
      do_req(1'b0, 16'h4000, 2'd3, 1'b0, '0, rd);

      for (int n = 0; n < 150; n++) begin
         rsize = 2'($urandom_range(0, 3));
         roff  = int'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) roff = roff & ~((1 << rsize) - 1);
         case ($urandom_range(0, 5))
            0:       raddr = 16'($urandom);
            1, 2:    raddr = 16'hBFF8 + 16'(roff);
            default: raddr = 16'h4000 + 16'(roff);
         endcase
         do_req(1'($urandom), raddr, rsize, 1'($urandom), {$urandom, $urandom}, rd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
